alu_issue_ctrl: RTL and testbench

//   Initiator side of the ALU interface. Accepts one decoded instruction per handshake,

---
 rtl/alu_issue_ctrl_pkg.sv | 31 +++
 rtl/alu_issue_ctrl_if.sv | 24 ++
 rtl/alu_issue_ctrl_seq_divider.sv | 59 +++++
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared codes for the ALU issue controller: ALU op encodings, MIPS ALUOp/funct values,
// FSM state type and the decoded-instruction payload.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_DIV = 4'b1010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic       is_div;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-side request and writeback-side response handshake of the ALU issue controller.
interface alu_issue_ctrl_if #(parameter int unsigned WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop_i;
    logic [5:0]       funct_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;

    modport master (
        output in_valid, aluop_i, funct_i, rs_i, rt_i, out_ready,
        input  in_ready, out_valid, result_o, zero_o, illegal_o
    );

    modport slave (
        input  in_valid, aluop_i, funct_i, rs_i, rt_i, out_ready,
        output in_ready, out_valid, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_issue_ctrl_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH iterations after start.
module alu_issue_ctrl_seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Shift in the next dividend bit; a clear top bit of diff means the subtract fits.
    always_comb begin
        rem_sh = {rem, quot[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= '0;
                quot    <= a;
                divisor <= b;
                count   <= CW'(WIDTH);
                busy    <= 1'b1;
            end else if (busy) begin
                quot  <= {quot[WIDTH-2:0], ~diff[WIDTH]};
                rem   <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                count <= count - CW'(1);
                if (count == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quot;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/funct, drives registered operands into the ALU,
// runs DIV on an internal iterative divider and returns the result via valid/ready.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_d, alu_b_d;
    logic [3:0]       alu_op_d;
    logic             ill_pend_q, ill_pend_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    dec_t             dec;

    function automatic dec_t decode(input logic [1:0] aluop, input logic [5:0] funct);
        dec_t d;
        d.op      = ALU_AND;
        d.is_div  = 1'b0;
        d.illegal = 1'b0;
        case (aluop)
            ALUOP_ADD:   d.op = ALU_ADD;
            ALUOP_SUB:   d.op = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: d.op = ALU_ADD;
                    FUNCT_SUB: d.op = ALU_SUB;
                    FUNCT_AND: d.op = ALU_AND;
                    FUNCT_OR:  d.op = ALU_OR;
                    FUNCT_SLT: d.op = ALU_SLT;
                    FUNCT_DIV: begin
                        d.op     = ALU_DIV;
                        d.is_div = 1'b1;
                    end
                    default:   d.illegal = 1'b1;
                endcase
            end
            default:     d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    alu_issue_ctrl_seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .a        (bus.rs_i),
        .b        (bus.rt_i),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Next-state and next-register values; everything holds unless a state acts on it.
    always_comb begin
        dec         = decode(bus.aluop_i, bus.funct_i);
        state_d     = state_q;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_op_d    = alu_op;
        ill_pend_d  = ill_pend_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    alu_a_d    = bus.rs_i;
                    alu_b_d    = bus.rt_i;
                    alu_op_d   = dec.op;
                    ill_pend_d = dec.illegal;
                    if (dec.is_div) begin
                        state_d   = DIV;
                        div_start = (bus.rt_i != '0);
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d  = ill_pend_q ? '0 : alu_res;
                zero_d    = ill_pend_q ? 1'b1 : alu_zero;
                illegal_d = ill_pend_q;
                state_d   = DONE;
            end
            DIV: begin
                // Divide by zero never starts the divider and answers all-ones at once.
                if (alu_b == '0) begin
                    result_d  = '1;
                    zero_d    = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end else if (div_done && !div_busy) begin
                    result_d  = div_quot;
                    zero_d    = (div_quot == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            ill_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_op      <= alu_op_d;
            ill_pend_q  <= ill_pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result_o  = result_q;
    assign bus.zero_o    = zero_q;
    assign bus.illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU attached.
module tb_alu_issue_ctrl;
    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    int               n_checks;
    int               n_errors;

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .alu_zero (alu_zero)
    );

    // The ALU's divide answer is deliberately bogus so any use of it shows up.
    always_comb begin
        case (alu_op)
            4'b0000: alu_res = alu_a & alu_b;
            4'b0001: alu_res = alu_a | alu_b;
            4'b0010: alu_res = alu_a + alu_b;
            4'b0110: alu_res = alu_a - alu_b;
            4'b0111: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'b1010: alu_res = 32'hDEAD_BEEF;
            default: alu_res = 32'h0BAD_0BAD;
        endcase
        alu_zero = (alu_res == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drop_out_valid", 32'(bus.out_valid), 32'd0);
        check("back_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] e_op,
                          input int e_lat, input logic [31:0] e_res, input logic e_zero,
                          input logic e_ill, input bit release_now);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.aluop_i  = aluop;
        bus.funct_i  = funct;
        bus.rs_i     = rs;
        bus.rt_i     = rt;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_alu_op"}, 32'(alu_op), 32'(e_op));
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_result"}, bus.result_o, e_res);
        check({tag, "_zero"}, 32'(bus.zero_o), 32'(e_zero));
        check({tag, "_illegal"}, 32'(bus.illegal_o), 32'(e_ill));
        if (release_now) take();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aluop_i   = 2'b00;
        bus.funct_i   = 6'b0;
        bus.rs_i      = '0;
        bus.rt_i      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_zero", 32'(bus.zero_o), 32'd0);
        check("rst_illegal", 32'(bus.illegal_o), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_r",    2'b10, 6'b100000, 32'd7,         32'd5,         4'b0010, 1,  32'd12,        1'b0, 1'b0, 1'b1);
        run_op("beq",      2'b01, 6'b000000, 32'h1234,      32'h1234,      4'b0110, 1,  32'd0,         1'b1, 1'b0, 1'b1);
        run_op("and",      2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 1,  32'h0000_F000, 1'b0, 1'b0, 1'b1);
        run_op("or",       2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_0F00, 4'b0001, 1,  32'h0000_FFF0, 1'b0, 1'b0, 1'b1);
        run_op("sub_wrap", 2'b10, 6'b100010, 32'd5,         32'd7,         4'b0110, 1,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        run_op("lw_wrap",  2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd2,         4'b0010, 1,  32'd1,         1'b0, 1'b0, 1'b1);
        run_op("slt_uns",  2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,         4'b0111, 1,  32'd0,         1'b1, 1'b0, 1'b1);
        run_op("div",      2'b10, 6'b011010, 32'd100,       32'd7,         4'b1010, 33, 32'd14,        1'b0, 1'b0, 1'b1);
        run_op("div_small",2'b10, 6'b011010, 32'd5,         32'd9,         4'b1010, 33, 32'd0,         1'b1, 1'b0, 1'b1);
        run_op("div_max",  2'b10, 6'b011010, 32'hFFFF_FFFF, 32'd1,         4'b1010, 33, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op("div_zero", 2'b10, 6'b011010, 32'd100,       32'd0,         4'b1010, 1,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        run_op("ill_funct",2'b10, 6'b111111, 32'd1,         32'd2,         4'b0000, 1,  32'd0,         1'b1, 1'b1, 1'b1);
        run_op("ill_aluop",2'b11, 6'b100000, 32'd1,         32'd2,         4'b0000, 1,  32'd0,         1'b1, 1'b1, 1'b1);
        run_op("slt_false",2'b10, 6'b101010, 32'd9,         32'd3,         4'b0111, 1,  32'd0,         1'b1, 1'b0, 1'b1);

        // Consumer stalls in DONE while a second request is offered and must be ignored.
        run_op("stall", 2'b10, 6'b100000, 32'd10, 32'd20, 4'b0010, 1, 32'd30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.aluop_i  = 2'b00;
                bus.rs_i     = 32'd1;
                bus.rt_i     = 32'd1;
            end
            @(posedge clk);
            #1;
            check("stall_result", bus.result_o, 32'd30);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        check("stall_alu_a_held", alu_a, 32'd10);
        bus.in_valid = 1'b0;
        take();
        check("after_stall_result", bus.result_o, 32'd30);

        // Reset partway through a divide.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluop_i  = 2'b10;
        bus.funct_i  = 6'b011010;
        bus.rs_i     = 32'd1000;
        bus.rt_i     = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("slt_after_rst", 2'b10, 6'b101010, 32'd3,    32'd9, 4'b0111, 1,  32'd1,   1'b0, 1'b0, 1'b1);
        run_op("div_after_rst", 2'b10, 6'b011010, 32'd1000, 32'd3, 4'b1010, 33, 32'd333, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
